tc_frame_rx: RTL and testbench

- Receive-side deserializer for the telecommand serial link.
- Consumes the serial clock/data pair driven by the TC serializer (tcclk_out, sout) and reassembles the NUM_WORDS x 32-bit payload words.
- Presents each word as a one-cycle strobe, flags frame completion, and flags truncated frames.
- Sits directly downstream of the serializer in the loopback/verification path and in the ground-side receiver.

---
 rtl/tc_pkg.sv | 16 +
 rtl/tc_frame_rx_if.sv | 27 ++
 rtl/tc_edge_sync.sv | 34 +++
 rtl/tc_frame_rx.sv | 158 +++++++++++++++
 tb/tb_tc_frame_rx.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/tc_pkg.sv
// Shared definitions for the telecommand serial link: payload geometry,
// receiver timing defaults and the receiver state encoding.
package tc_pkg;

    localparam int TC_WORD_W      = 32;
    localparam int TC_NUM_WORDS   = 10;
    localparam int TC_GAP_CYCLES  = 64;
    localparam int TC_SYNC_STAGES = 2;
    localparam int TC_IDX_W       = 4;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RECV = 1'b1
    } rx_state_e;

endpackage

// File: rtl/tc_frame_rx_if.sv
// Serial input pair plus word/frame output strobes of the telecommand receiver.
// master = link side driving the serial pins, slave = receiver.
interface tc_frame_rx_if #(
    parameter int WORD_W = tc_pkg::TC_WORD_W
);
    import tc_pkg::*;

    logic                tcclk_in;
    logic                sin;
    logic [WORD_W-1:0]   word_data;
    logic [TC_IDX_W-1:0] word_idx;
    logic                word_valid;
    logic                frame_done;
    logic                frame_err;
    logic                busy;

    modport master (
        output tcclk_in, sin,
        input  word_data, word_idx, word_valid, frame_done, frame_err, busy
    );

    modport slave (
        input  tcclk_in, sin,
        output word_data, word_idx, word_valid, frame_done, frame_err, busy
    );

endinterface

// File: rtl/tc_edge_sync.sv
// Equal-depth synchronisers for a serial clock/data pair, with rising-edge
// detection on the synchronised clock so data and edge stay aligned.
module tc_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clk_in,
    input  logic data_in,
    output logic sin_s,
    output logic clk_rise
);

    logic [SYNC_STAGES-1:0] clk_sync_r;
    logic [SYNC_STAGES-1:0] dat_sync_r;
    logic                   clk_prev_r;

    // Synchroniser chains and previous-value flop for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync_r <= {SYNC_STAGES{1'b0}};
            dat_sync_r <= {SYNC_STAGES{1'b0}};
            clk_prev_r <= 1'b0;
        end else begin
            clk_sync_r <= {clk_sync_r[SYNC_STAGES-2:0], clk_in};
            dat_sync_r <= {dat_sync_r[SYNC_STAGES-2:0], data_in};
            clk_prev_r <= clk_sync_r[SYNC_STAGES-1];
        end
    end

    assign sin_s    = dat_sync_r[SYNC_STAGES-1];
    assign clk_rise = clk_sync_r[SYNC_STAGES-1] & ~clk_prev_r;

endmodule

// File: rtl/tc_frame_rx.sv
// Telecommand frame receiver: deserialises NUM_WORDS MSB-first words from the
// serial clock/data pair, strobing each word, frame completion and gap timeouts.
module tc_frame_rx import tc_pkg::*; #(
    parameter int WORD_W      = TC_WORD_W,
    parameter int NUM_WORDS   = TC_NUM_WORDS,
    parameter int GAP_CYCLES  = TC_GAP_CYCLES,
    parameter int SYNC_STAGES = TC_SYNC_STAGES
) (
    input  logic          sysclk,
    input  logic          reset,
    tc_frame_rx_if.slave  rx
);

    localparam int BIT_W  = $clog2(WORD_W);
    localparam int WCNT_W = $clog2(NUM_WORDS);
    localparam int GAP_W  = $clog2(GAP_CYCLES);

    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WORD_W - 1);
    localparam logic [WCNT_W-1:0] WORD_LAST = WCNT_W'(NUM_WORDS - 1);
    localparam logic [GAP_W-1:0]  GAP_TRIP  = GAP_W'(GAP_CYCLES - 2);
    localparam logic [GAP_W-1:0]  GAP_MAX   = GAP_W'(GAP_CYCLES - 1);

    logic sin_s;
    logic clk_rise_s;

    rx_state_e           state_r,     state_next_s;
    logic [WORD_W-1:0]   shift_r,     shift_next_s;
    logic [BIT_W-1:0]    bit_cnt_r,   bit_cnt_next_s;
    logic [WCNT_W-1:0]   word_cnt_r,  word_cnt_next_s;
    logic [GAP_W-1:0]    gap_cnt_r,   gap_cnt_next_s;
    logic [WORD_W-1:0]   word_data_r, word_data_next_s;
    logic [TC_IDX_W-1:0] word_idx_r,  word_idx_next_s;
    logic                word_valid_r, word_valid_next_s;
    logic                frame_done_r, frame_done_next_s;
    logic                frame_err_r,  frame_err_next_s;
    logic                busy_r,       busy_next_s;
    logic [WORD_W-1:0]   shifted_s;

    tc_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk      (sysclk),
        .rst      (reset),
        .clk_in   (rx.tcclk_in),
        .data_in  (rx.sin),
        .sin_s    (sin_s),
        .clk_rise (clk_rise_s)
    );

    assign shifted_s = {shift_r[WORD_W-2:0], sin_s};

    // Next-state and output decode for the IDLE/RECV receiver
    always_comb begin
        state_next_s      = state_r;
        shift_next_s      = shift_r;
        bit_cnt_next_s    = bit_cnt_r;
        word_cnt_next_s   = word_cnt_r;
        gap_cnt_next_s    = gap_cnt_r;
        word_data_next_s  = word_data_r;
        word_idx_next_s   = word_idx_r;
        word_valid_next_s = 1'b0;
        frame_done_next_s = 1'b0;
        frame_err_next_s  = 1'b0;
        case (state_r)
            IDLE: begin
                gap_cnt_next_s = {GAP_W{1'b0}};
                if (clk_rise_s) begin
                    shift_next_s    = {{(WORD_W-1){1'b0}}, sin_s};
                    bit_cnt_next_s  = BIT_W'(1);
                    word_cnt_next_s = {WCNT_W{1'b0}};
                    state_next_s    = RECV;
                end else begin
                    state_next_s    = IDLE;
                end
            end
            RECV: begin
                if (clk_rise_s) begin
                    shift_next_s   = shifted_s;
                    bit_cnt_next_s = bit_cnt_r + BIT_W'(1);
                    gap_cnt_next_s = {GAP_W{1'b0}};
                    if (bit_cnt_r == BIT_LAST) begin
                        word_data_next_s  = shifted_s;
                        word_idx_next_s   = TC_IDX_W'(word_cnt_r);
                        word_valid_next_s = 1'b1;
                        bit_cnt_next_s    = {BIT_W{1'b0}};
                        if (word_cnt_r == WORD_LAST) begin
                            frame_done_next_s = 1'b1;
                            shift_next_s      = {WORD_W{1'b0}};
                            word_cnt_next_s   = {WCNT_W{1'b0}};
                            state_next_s      = IDLE;
                        end else begin
                            word_cnt_next_s   = word_cnt_r + WCNT_W'(1);
                        end
                    end else begin
                        word_valid_next_s = 1'b0;
                    end
                end else if (gap_cnt_r == GAP_TRIP) begin
                    // Counter reaches GAP_CYCLES-1 this cycle: abandon the partial frame
                    frame_err_next_s = 1'b1;
                    shift_next_s     = {WORD_W{1'b0}};
                    bit_cnt_next_s   = {BIT_W{1'b0}};
                    word_cnt_next_s  = {WCNT_W{1'b0}};
                    gap_cnt_next_s   = {GAP_W{1'b0}};
                    state_next_s     = IDLE;
                end else if (gap_cnt_r != GAP_MAX) begin
                    gap_cnt_next_s   = gap_cnt_r + GAP_W'(1);
                end else begin
                    gap_cnt_next_s   = gap_cnt_r;
                end
            end
            default: begin
                state_next_s    = IDLE;
                shift_next_s    = {WORD_W{1'b0}};
                bit_cnt_next_s  = {BIT_W{1'b0}};
                word_cnt_next_s = {WCNT_W{1'b0}};
                gap_cnt_next_s  = {GAP_W{1'b0}};
            end
        endcase
        busy_next_s = (state_next_s == RECV);
    end

    // State, datapath and registered output flops
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            shift_r      <= {WORD_W{1'b0}};
            bit_cnt_r    <= {BIT_W{1'b0}};
            word_cnt_r   <= {WCNT_W{1'b0}};
            gap_cnt_r    <= {GAP_W{1'b0}};
            word_data_r  <= {WORD_W{1'b0}};
            word_idx_r   <= {TC_IDX_W{1'b0}};
            word_valid_r <= 1'b0;
            frame_done_r <= 1'b0;
            frame_err_r  <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            shift_r      <= shift_next_s;
            bit_cnt_r    <= bit_cnt_next_s;
            word_cnt_r   <= word_cnt_next_s;
            gap_cnt_r    <= gap_cnt_next_s;
            word_data_r  <= word_data_next_s;
            word_idx_r   <= word_idx_next_s;
            word_valid_r <= word_valid_next_s;
            frame_done_r <= frame_done_next_s;
            frame_err_r  <= frame_err_next_s;
            busy_r       <= busy_next_s;
        end
    end

    assign rx.word_data  = word_data_r;
    assign rx.word_idx   = word_idx_r;
    assign rx.word_valid = word_valid_r;
    assign rx.frame_done = frame_done_r;
    assign rx.frame_err  = frame_err_r;
    assign rx.busy       = busy_r;

endmodule

// File: tb/tb_tc_frame_rx.sv
// Bench for tc_frame_rx: serialises frames onto the pins and checks every
// cycle against a frame-level model built from edge detect times and bit values.
module tb_tc_frame_rx;
    import tc_pkg::*;

    localparam int W   = TC_WORD_W;
    localparam int NW  = TC_NUM_WORDS;
    localparam int GAP = TC_GAP_CYCLES;
    localparam int SS  = TC_SYNC_STAGES;

    localparam logic [31:0] LIT [NW] = '{
        32'hAAAAAAAA, 32'hCCCCCCCC, 32'hE38E38E3, 32'hF0F0F0F0, 32'hF83E0F83,
        32'hFC0FC0FC, 32'h77777777, 32'h88888888, 32'h99999999, 32'hAAAAAAAA
    };

    typedef struct {
        int   d;
        logic b;
    } edge_t;

    logic sysclk = 1'b0;
    logic reset  = 1'b1;
    int   cyc    = 0;

    tc_frame_rx_if #(.WORD_W(W)) bus();

    tc_frame_rx #(
        .WORD_W      (W),
        .NUM_WORDS   (NW),
        .GAP_CYCLES  (GAP),
        .SYNC_STAGES (SS)
    ) dut (
        .sysclk (sysclk),
        .reset  (reset),
        .rx     (bus)
    );

    always #10 sysclk = ~sysclk;

    always @(posedge sysclk) cyc <= cyc + 1;

    int          checks = 0;
    int          errors = 0;
    edge_t       edge_q[$];
    logic [31:0] frm [2*NW];

    // frame-level model state
    bit          in_frame = 1'b0;
    logic [31:0] acc = 32'd0;
    int          nbits = 0;
    int          widx  = 0;
    int          last  = 0;
    logic        exp_valid = 1'b0, exp_done = 1'b0, exp_err = 1'b0, exp_busy = 1'b0;
    logic [31:0] exp_data = 32'd0;
    logic [3:0]  exp_idx  = 4'd0;

    // DUT strobe log
    logic [31:0] got_words[$];
    int          got_idx[$];
    int          n_done = 0;
    int          n_err  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] vec(input logic v, input logic d, input logic e,
                                        input logic b, input logic [3:0] idx, input logic [31:0] data);
        return {24'd0, v, d, e, b, idx, data};
    endfunction

    // Advance the model by the cycle cyc: a bit arriving, or the gap rule firing.
    task automatic model_step();
        edge_t e;
        bit    hit;
        hit = 1'b0;
        exp_valid = 1'b0;
        exp_done  = 1'b0;
        exp_err   = 1'b0;
        if (edge_q.size() > 0 && edge_q[0].d == cyc) begin
            e   = edge_q.pop_front();
            hit = 1'b1;
        end
        if (hit) begin
            if (!in_frame) begin
                in_frame = 1'b1;
                acc = 32'd0;
                nbits = 0;
                widx = 0;
            end
            acc = {acc[30:0], e.b};
            nbits++;
            last = cyc;
            if (nbits == W) begin
                exp_valid = 1'b1;
                exp_data  = acc;
                exp_idx   = 4'(widx);
                exp_done  = (widx == NW - 1);
                widx++;
                nbits = 0;
                if (exp_done) in_frame = 1'b0;
            end
        end else if (in_frame && (cyc - last) >= GAP - 1) begin
            exp_err  = 1'b1;
            in_frame = 1'b0;
        end
        exp_busy = in_frame;
    endtask

    // One sysclk cycle: compare at the falling edge, then step to just after the rising edge.
    task automatic tick();
        @(negedge sysclk);
        if (reset) begin
            chk("reset_outputs",
                vec(bus.word_valid, bus.frame_done, bus.frame_err, bus.busy, bus.word_idx, bus.word_data),
                64'd0);
            in_frame = 1'b0;
            edge_q.delete();
            exp_valid = 1'b0; exp_done = 1'b0; exp_err = 1'b0; exp_busy = 1'b0;
            exp_data = 32'd0; exp_idx = 4'd0;
        end else begin
            chk("cycle_outputs",
                vec(bus.word_valid, bus.frame_done, bus.frame_err, bus.busy, bus.word_idx, bus.word_data),
                vec(exp_valid, exp_done, exp_err, exp_busy, exp_idx, exp_data));
            if (bus.word_valid === 1'b1) begin
                got_words.push_back(bus.word_data);
                got_idx.push_back(int'(bus.word_idx));
            end
            if (bus.frame_done === 1'b1) n_done++;
            if (bus.frame_err === 1'b1) n_err++;
            model_step();
        end
        @(posedge sysclk);
        #2;
    endtask

    task automatic send_bit(input logic b, input int lo, input int hi);
        bus.sin      = b;
        bus.tcclk_in = 1'b0;
        repeat (lo) tick();
        bus.tcclk_in = 1'b1;
        edge_q.push_back('{cyc + SS, b});
        repeat (hi) tick();
    endtask

    task automatic send_bits(input int nb, input int lo, input int hi);
        for (int i = 0; i < nb; i++) begin
            logic [31:0] w;
            w = frm[i / W];
            send_bit(w[W - 1 - (i % W)], lo, hi);
        end
    endtask

    task automatic idle(input int n);
        bus.tcclk_in = 1'b0;
        repeat (n) tick();
    endtask

    task automatic fill_random();
        for (int i = 0; i < 2 * NW; i++) frm[i] = $urandom;
    endtask

    int b0, d0, e0;

    initial begin
        bus.tcclk_in = 1'b0;
        bus.sin      = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        idle(4);
        chk_int("idle_busy", int'(bus.busy), 0);
        chk("idle_word_data", 64'(bus.word_data), 64'd0);

        // full frame of known words, 40 ns bit period
        for (int i = 0; i < NW; i++) frm[i] = LIT[i];
        b0 = got_words.size(); d0 = n_done; e0 = n_err;
        send_bits(NW * W, 1, 1);
        idle(GAP + 10);
        chk_int("p1_word_count", got_words.size() - b0, NW);
        for (int i = 0; i < NW; i++) begin
            chk("p1_word", 64'(got_words[b0 + i]), 64'(LIT[i]));
            chk_int("p1_idx", got_idx[b0 + i], i);
        end
        chk_int("p1_done", n_done - d0, 1);
        chk_int("p1_err", n_err - e0, 0);
        chk("p1_model_last", 64'(exp_data), 64'hAAAAAAAA);

        // mid-word gap after 100 bits, then a clean frame
        fill_random();
        b0 = got_words.size(); d0 = n_done; e0 = n_err;
        send_bits(100, 2, 2);
        idle(GAP + 5);
        chk_int("p2_partial_words", got_words.size() - b0, 3);
        chk_int("p2_err", n_err - e0, 1);
        chk_int("p2_done", n_done - d0, 0);
        chk_int("p2_busy", int'(bus.busy), 0);
        chk("p2_word2", 64'(got_words[b0 + 2]), 64'(frm[2]));
        fill_random();
        b0 = got_words.size();
        send_bits(NW * W, 2, 3);
        idle(GAP + 10);
        chk_int("p2_next_words", got_words.size() - b0, NW);
        chk("p2_next_last", 64'(got_words[b0 + NW - 1]), 64'(frm[NW - 1]));

        // edge spacing GAP-1 completes, spacing GAP times out on every edge
        fill_random();
        b0 = got_words.size(); e0 = n_err;
        send_bits(NW * W, (GAP - 1) / 2, GAP - 1 - (GAP - 1) / 2);
        idle(GAP + 10);
        chk_int("p3_words_gap_m1", got_words.size() - b0, NW);
        chk_int("p3_err_gap_m1", n_err - e0, 0);
        b0 = got_words.size(); e0 = n_err;
        send_bits(3, GAP / 2, GAP - GAP / 2);
        idle(GAP + 10);
        chk_int("p3_err_gap", n_err - e0, 3);
        chk_int("p3_words_gap", got_words.size() - b0, 0);

        // reset at bit 200
        fill_random();
        b0 = got_words.size(); e0 = n_err;
        send_bits(200, 2, 2);
        idle(4);
        reset = 1'b1;
        repeat (3) tick();
        chk_int("p4_rst_busy", int'(bus.busy), 0);
        chk_int("p4_rst_valid", int'(bus.word_valid), 0);
        chk("p4_rst_data", 64'(bus.word_data), 64'd0);
        reset = 1'b0;
        chk_int("p4_words_before", got_words.size() - b0, 6);
        idle(5);
        fill_random();
        b0 = got_words.size();
        send_bits(NW * W, 2, 2);
        idle(GAP + 10);
        chk_int("p4_words_after", got_words.size() - b0, NW);
        chk_int("p4_first_idx", got_idx[b0], 0);
        chk_int("p4_err", n_err - e0, 0);

        // back-to-back frames, no idle bit
        fill_random();
        b0 = got_words.size(); d0 = n_done;
        send_bits(2 * NW * W, 2, 2);
        idle(GAP + 10);
        chk_int("p5_words", got_words.size() - b0, 2 * NW);
        chk_int("p5_done", n_done - d0, 2);
        chk_int("p5_idx_restart", got_idx[b0 + NW], 0);
        chk_int("p5_idx_last", got_idx[b0 + 2 * NW - 1], NW - 1);
        chk("p5_word_b0", 64'(got_words[b0 + NW]), 64'(frm[NW]));

        // stray edge after a complete frame
        b0 = got_words.size(); e0 = n_err;
        send_bits(1, 3, 3);
        idle(GAP + 10);
        chk_int("p6_err", n_err - e0, 1);
        chk_int("p6_words", got_words.size() - b0, 0);
        chk_int("model_drained", edge_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
